// File: rtl/pack_counter_bank_pkg.sv
// Shared types and category indices for the pack counter bank.
// Channel FSM states plus the fixed mapping of sock categories to channels.
package pack_counter_bank_pkg;

    typedef enum logic {
        ST_COUNT = 1'b0,
        ST_FULL  = 1'b1
    } ch_state_e;

    localparam int CH_ALG_BAJO = 0;
    localparam int CH_POL_BAJO = 1;
    localparam int CH_ACR_BAJO = 2;
    localparam int CH_ALG_ALTO = 3;
    localparam int CH_ACR_ALTO = 4;

endpackage

// File: rtl/pack_channel.sv
// One sock-category channel: counts accepted pairs into a pack, holds a full pack until ack.
// Latency 1 cycle from inc/ack to outputs; a full channel only frees up through ack_i.
module pack_channel
    import pack_counter_bank_pkg::*;
#(
    parameter int CNT_W     = 3,
    parameter int PACKS_W   = 3,
    parameter int PACK_SIZE = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear_i,
    input  logic               inc_i,
    input  logic               ack_i,
    output logic [CNT_W-1:0]   unit_cnt_o,
    output logic [PACKS_W-1:0] pack_cnt_o,
    output logic               pack_full_o
);

    ch_state_e          state_q;
    logic [CNT_W-1:0]   unit_q;
    logic [CNT_W-1:0]   unit_d;
    logic [PACKS_W-1:0] pack_q;
    logic               full_q;

    assign unit_d = unit_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_COUNT;
            unit_q  <= '0;
            pack_q  <= '0;
            full_q  <= 1'b0;
        end else if (clear_i) begin
            state_q <= ST_COUNT;
            unit_q  <= '0;
            pack_q  <= '0;
            full_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_COUNT: begin
                    if (inc_i) begin
                        unit_q <= unit_d;
                        if (unit_d == CNT_W'(PACK_SIZE)) begin
                            state_q <= ST_FULL;
                            full_q  <= 1'b1;
                        end
                    end
                end
                ST_FULL: begin
                    if (ack_i) begin
                        // A pair arriving with the ack starts the next pack.
                        unit_q  <= inc_i ? CNT_W'(1) : '0;
                        state_q <= ST_COUNT;
                        full_q  <= 1'b0;
                        if (pack_q != {PACKS_W{1'b1}}) begin
                            pack_q <= pack_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_COUNT;
                end
            endcase
        end
    end

    assign unit_cnt_o  = unit_q;
    assign pack_cnt_o  = pack_q;
    assign pack_full_o = full_q;

endmodule

// File: rtl/pack_counter_bank.sv
// Multi-channel pack counter: edge-detects offered pairs, routes them to per-category channels.
// Latency 1 cycle from offer to counts/drop_err; offers to a full, unacked channel are dropped.
module pack_counter_bank
    import pack_counter_bank_pkg::*;
#(
    parameter int NUM_CH    = 5,
    parameter int PACK_SIZE = 7,
    parameter int CNT_W     = 3,
    parameter int PACKS_W   = 3,
    parameter int SEL_W     = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      item_valid,
    input  logic [SEL_W-1:0]          item_ch,
    input  logic                      sensor_ok,
    input  logic [NUM_CH-1:0]         pack_ack,
    input  logic                      clear_all,
    output logic [NUM_CH*CNT_W-1:0]   unit_cnt,
    output logic [NUM_CH*PACKS_W-1:0] pack_cnt,
    output logic [NUM_CH-1:0]         pack_full,
    output logic                      drop_err
);

    if (PACK_SIZE < 2 || PACK_SIZE >= (2 ** CNT_W) || (2 ** SEL_W) < NUM_CH) begin : g_bad_cfg
        $error("pack_counter_bank: illegal PACK_SIZE/CNT_W/SEL_W/NUM_CH combination");
    end

    logic              item_valid_q;
    logic              armed_q;
    logic              drop_q;
    logic              drop_d;
    logic              offer;
    logic [NUM_CH-1:0] inc;

    // The first clock after reset only loads history, so a level held high across
    // reset release is not mistaken for a fresh pair.
    assign offer = item_valid & ~item_valid_q & armed_q;

    always_comb begin
        inc = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (offer && sensor_ok && item_ch == SEL_W'(i) && (!pack_full[i] || pack_ack[i])) begin
                inc[i] = 1'b1;
            end
        end
        drop_d = offer && sensor_ok && (inc == '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            item_valid_q <= 1'b0;
            armed_q      <= 1'b0;
            drop_q       <= 1'b0;
        end else begin
            item_valid_q <= item_valid;
            armed_q      <= 1'b1;
            drop_q       <= clear_all ? 1'b0 : drop_d;
        end
    end

    assign drop_err = drop_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        pack_channel #(
            .CNT_W     (CNT_W),
            .PACKS_W   (PACKS_W),
            .PACK_SIZE (PACK_SIZE)
        ) u_ch (
            .clk         (clk),
            .rst_n       (reset),
            .clear_i     (clear_all),
            .inc_i       (inc[g]),
            .ack_i       (pack_ack[g]),
            .unit_cnt_o  (unit_cnt[g*CNT_W +: CNT_W]),
            .pack_cnt_o  (pack_cnt[g*PACKS_W +: PACKS_W]),
            .pack_full_o (pack_full[g])
        );
    end

endmodule

// File: tb/tb_pack_counter_bank.sv
// Bench for pack_counter_bank: directed scenarios then random traffic against a pack-level model.
module tb_pack_counter_bank;
    import pack_counter_bank_pkg::*;

    localparam int NUM_CH    = 5;
    localparam int PACK_SIZE = 7;
    localparam int CNT_W     = 3;
    localparam int PACKS_W   = 3;
    localparam int SEL_W     = 3;
    localparam int PACK_MAX  = (2 ** PACKS_W) - 1;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      item_valid;
    logic [SEL_W-1:0]          item_ch;
    logic                      sensor_ok;
    logic [NUM_CH-1:0]         pack_ack;
    logic                      clear_all;
    logic [NUM_CH*CNT_W-1:0]   unit_cnt;
    logic [NUM_CH*PACKS_W-1:0] pack_cnt;
    logic [NUM_CH-1:0]         pack_full;
    logic                      drop_err;

    always #5 clk = ~clk;

    pack_counter_bank #(
        .NUM_CH(NUM_CH), .PACK_SIZE(PACK_SIZE), .CNT_W(CNT_W), .PACKS_W(PACKS_W), .SEL_W(SEL_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .item_valid (item_valid),
        .item_ch    (item_ch),
        .sensor_ok  (sensor_ok),
        .pack_ack   (pack_ack),
        .clear_all  (clear_all),
        .unit_cnt   (unit_cnt),
        .pack_cnt   (pack_cnt),
        .pack_full  (pack_full),
        .drop_err   (drop_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: how many pairs sit in each open pack, and how many packs were shipped.
    int m_units[NUM_CH];
    int m_packs[NUM_CH];
    bit m_prev;
    bit m_armed;
    bit m_drop;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_units[c] = 0;
            m_packs[c] = 0;
        end
        m_prev  = 1'b0;
        m_armed = 1'b0;
        m_drop  = 1'b0;
    endfunction

    function automatic void model_step(input bit iv, input int ch, input bit sens,
                                       input logic [NUM_CH-1:0] ack, input bit clr);
        bit new_pair;
        int taker;
        new_pair = iv && !m_prev && m_armed;
        m_prev   = iv;
        m_armed  = 1'b1;
        taker    = -1;
        m_drop   = 1'b0;
        if (clr) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_units[c] = 0;
                m_packs[c] = 0;
            end
            return;
        end
        if (new_pair && sens) begin
            if (ch < NUM_CH && (m_units[ch] < PACK_SIZE || ack[ch])) taker = ch;
            else m_drop = 1'b1;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (m_units[c] == PACK_SIZE && ack[c]) begin
                m_units[c] = 0;
                if (m_packs[c] < PACK_MAX) m_packs[c]++;
            end
        end
        if (taker >= 0) m_units[taker]++;
    endfunction

    task automatic check_outputs(input string tag);
        logic [NUM_CH*CNT_W-1:0]   e_unit;
        logic [NUM_CH*PACKS_W-1:0] e_pack;
        logic [NUM_CH-1:0]         e_full;
        for (int c = 0; c < NUM_CH; c++) begin
            e_unit[c*CNT_W +: CNT_W]     = CNT_W'(m_units[c]);
            e_pack[c*PACKS_W +: PACKS_W] = PACKS_W'(m_packs[c]);
            e_full[c]                    = (m_units[c] == PACK_SIZE);
        end
        chk({tag, ".unit_cnt"},  64'(unit_cnt),  64'(e_unit));
        chk({tag, ".pack_cnt"},  64'(pack_cnt),  64'(e_pack));
        chk({tag, ".pack_full"}, 64'(pack_full), 64'(e_full));
        chk({tag, ".drop_err"},  64'(drop_err),  64'(m_drop));
    endtask

    task automatic tick(input bit iv, input int ch, input bit sens,
                        input logic [NUM_CH-1:0] ack, input bit clr, input string tag);
        item_valid = iv;
        item_ch    = ch[SEL_W-1:0];
        sensor_ok  = sens;
        pack_ack   = ack;
        clear_all  = clr;
        model_step(iv, ch, sens, ack, clr);
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic offer(input int ch, input bit sens, input string tag);
        tick(1'b1, ch, sens, '0, 1'b0, tag);
        tick(1'b0, ch, sens, '0, 1'b0, tag);
    endtask

    initial begin
        logic [31:0] r;
        reset      = 1'b0;
        item_valid = 1'b1;
        item_ch    = '0;
        sensor_ok  = 1'b1;
        pack_ack   = '0;
        clear_all  = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs("reset");
        @(negedge clk);
        reset = 1'b1;
        repeat (3) tick(1'b1, CH_ALG_BAJO, 1'b1, '0, 1'b0, "rst_hold");
        chk("rst_hold_nocount", 64'(unit_cnt), 64'd0);
        tick(1'b0, CH_ALG_BAJO, 1'b1, '0, 1'b0, "rst_low");

        for (int k = 0; k < PACK_SIZE; k++) offer(CH_ALG_BAJO, 1'b1, "fill0");
        chk("fill0_full", 64'(pack_full[0]), 64'd1);
        chk("fill0_unit", 64'(unit_cnt[2:0]), 64'd7);

        tick(1'b1, CH_ALG_BAJO, 1'b1, '0, 1'b0, "full_drop");
        chk("full_drop_pulse", 64'(drop_err), 64'd1);
        tick(1'b0, CH_ALG_BAJO, 1'b1, '0, 1'b0, "full_drop_end");
        chk("full_drop_clear", 64'(drop_err), 64'd0);
        tick(1'b0, CH_ALG_BAJO, 1'b1, 5'b00001, 1'b0, "ack0");
        chk("ack0_pack", 64'(pack_cnt[2:0]), 64'd1);

        for (int k = 0; k < PACK_SIZE; k++) offer(CH_ALG_ALTO, 1'b1, "fill3");
        tick(1'b1, CH_ALG_ALTO, 1'b1, 5'b01000, 1'b0, "ack_offer3");
        chk("ack_offer3_unit", 64'(unit_cnt[11:9]), 64'd1);
        chk("ack_offer3_pack", 64'(pack_cnt[11:9]), 64'd1);
        tick(1'b0, CH_ALG_ALTO, 1'b1, '0, 1'b0, "ack_offer3_end");

        tick(1'b1, 6, 1'b1, '0, 1'b0, "bad_ch");
        chk("bad_ch_drop", 64'(drop_err), 64'd1);
        tick(1'b0, 6, 1'b1, '0, 1'b0, "bad_ch_end");
        tick(1'b1, CH_ACR_BAJO, 1'b0, '0, 1'b0, "no_sensor");
        chk("no_sensor_drop", 64'(drop_err), 64'd0);
        tick(1'b0, CH_ACR_BAJO, 1'b0, '0, 1'b0, "no_sensor_end");

        for (int p = 0; p < 8; p++) begin
            for (int k = 0; k < PACK_SIZE; k++) offer(CH_POL_BAJO, 1'b1, "sat1");
            tick(1'b0, CH_POL_BAJO, 1'b1, 5'b00010, 1'b0, "sat1_ack");
        end
        chk("sat1_pack", 64'(pack_cnt[5:3]), 64'd7);

        tick(1'b1, CH_ACR_ALTO, 1'b1, '0, 1'b1, "clear");
        chk("clear_units", 64'(unit_cnt), 64'd0);
        chk("clear_packs", 64'(pack_cnt), 64'd0);
        tick(1'b0, CH_ACR_ALTO, 1'b1, '0, 1'b0, "clear_end");

        for (int n = 0; n < 1500; n++) begin
            r = $urandom & $urandom;
            tick(1'($urandom_range(0, 1)), $urandom_range(0, 7), ($urandom_range(0, 9) != 0),
                 r[NUM_CH-1:0], ($urandom_range(0, 199) == 0), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pack_counter_bank.md
Name: pack_counter_bank

Overview:
- Parametrised multi-channel successor to the per-type sock counters; a single block replaces one counter instance per sock type.
- Counts finished pairs leaving the forming stage, one channel per sock category, up to a configurable pack size.
- Holds each full pack until the packing station acknowledges its removal, and keeps a saturating pack tally per channel.
- Sits between the forming (hormado) stage and the packing display LEDs/outputs.

Parameters:
- NUM_CH, 5: number of sock categories/channels (1..8).
- PACK_SIZE, 7: pairs per pack (2..2**CNT_W-1).
- CNT_W, 3: width of per-channel pair count.
- PACKS_W, 3: width of per-channel completed-pack tally.
- SEL_W, 3: width of channel select; 2**SEL_W >= NUM_CH.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- item_valid  in  1  level from forming stage; a pair is offered on each 0->1 edge.
- item_ch  in  SEL_W  channel of the offered pair; sampled on the item_valid rising edge.
- sensor_ok  in  1  presence sensor; a pair is counted only if high at the edge.
- pack_ack  in  NUM_CH  per-channel pack-removed acknowledge, level-sampled.
- clear_all  in  1  synchronous clear of all counts and tallies.
- unit_cnt  out  NUM_CH*CNT_W  pairs in current pack; channel i at [i*CNT_W +: CNT_W].
- pack_cnt  out  NUM_CH*PACKS_W  completed packs per channel, saturating.
- pack_full  out  NUM_CH  channel holds a full pack awaiting ack.
- drop_err  out  1  one-cycle pulse; an offered pair was rejected.

Behaviour:
- Reset (reset=0, asynchronous): all channels go to COUNT. unit_cnt=0, pack_cnt=0, pack_full=0, drop_err=0. The edge-detector history register is cleared to 0.
  - item_valid held high through reset release does not create an edge.
- Edge detect: offer = item_valid & ~item_valid_q. All outputs are registered, so effects are visible 1 cycle after the offer cycle.
- An offer is accepted only when all of the following hold:
  - sensor_ok=1;
  - item_ch < NUM_CH;
  - the target channel is in COUNT, or is in FULL with pack_ack[ch]=1 in the same cycle.
- Any other offer is rejected: drop_err=1 on the next cycle and no counter changes. An offer with sensor_ok=0 is silently ignored, with no drop_err.
- Per-channel FSM, 2 states:
  - COUNT: on an accepted offer, unit_cnt += 1. If the new value equals PACK_SIZE, go to FULL and set pack_full=1. pack_ack is ignored in COUNT.
  - FULL: unit_cnt stays at PACK_SIZE.
    - On pack_ack[ch]=1: unit_cnt <= 0, pack_cnt += 1 (saturating at 2**PACKS_W-1, no wrap), go to COUNT, pack_full <= 0.
    - Ack and an accepted offer in the same cycle: the pack is retired and the pair becomes the first of the new pack, giving unit_cnt=1, pack_cnt+1, state COUNT.
- Channels are independent. Acks on several channels in one cycle are all processed.
- clear_all=1 (synchronous) takes priority over offers and acks. All channels go to COUNT with counts and tallies zero; drop_err <= 0. The edge history still updates.
- PACK_SIZE=1 is illegal. An elaboration-time check fails if PACK_SIZE >= 2**CNT_W or 2**SEL_W < NUM_CH.

Decomposition:
- Shared package: channel FSM state enum (ST_COUNT, ST_FULL) and category index constants (CH_ALG_BAJO=0, CH_POL_BAJO=1, CH_ACR_BAJO=2, CH_ALG_ALTO=3, CH_ACR_ALTO=4).
- One sub-module, pack_channel: a single-channel FSM with unit and pack counters, instantiated NUM_CH times by a generate loop.
- The top level holds the edge detector, channel decode and drop_err register.

Test Plan:
- Reset: hold reset=0 with item_valid=1, then release -> all outputs 0, and no count occurs until item_valid falls and rises again.
- Fill channel 0: 7 offers on ch 0 with sensor_ok=1 -> unit_cnt[0] steps 1..7, pack_full[0]=1 the cycle after the 7th offer; other channels stay 0.
- Reject while full: 8th offer on ch 0 without ack -> drop_err pulses 1 cycle, unit_cnt[0]=7, pack_cnt[0]=0. Then pack_ack[0]=1 -> unit_cnt[0]=0, pack_cnt[0]=1, pack_full[0]=0.
- Simultaneous ack and offer on full ch 3 -> unit_cnt[3]=1, pack_cnt[3]=1, pack_full[3]=0, drop_err=0.
- Invalid cases:
  - item_ch=6 -> drop_err=1 and no counter change;
  - sensor_ok=0 offer -> no change, drop_err=0.
- Saturation and clear:
  - 8 full/ack cycles on ch 1 -> pack_cnt[1] stays 7;
  - clear_all=1 together with an offer -> all counts 0 next cycle, offer discarded.
